// File: rtl/click_frontend.sv
// Player-button front end: 2-flop sync, per-channel debounce, rise detection and
// round-robin serialisation of presses into one-hot single-cycle click pulses.
module click_frontend #(
  parameter int N_PLAYERS       = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_PLAYERS-1:0] btn_raw,
  output logic [N_PLAYERS-1:0] click,
  output logic [N_PLAYERS-1:0] btn_level,
  output logic [N_PLAYERS-1:0] overrun
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_PLAYERS-1:0] s1_q, s2_q;
  logic [N_PLAYERS-1:0] level_q, level_d;
  logic [CW-1:0]        cnt_q [N_PLAYERS];
  logic [CW-1:0]        cnt_d [N_PLAYERS];
  logic [N_PLAYERS-1:0] pending_q, pending_d;
  logic [N_PLAYERS-1:0] click_q, click_d;
  logic [N_PLAYERS-1:0] overrun_q, overrun_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [N_PLAYERS-1:0] rise_s;
  logic [PW:0]          pick_s;
  logic                 grant_valid_s;
  logic [PW-1:0]        grant_idx_s;

  // Returns {valid, index} of the first request found scanning from ptr upwards.
  function automatic logic [PW:0] rr_pick(input logic [N_PLAYERS-1:0] req,
                                          input logic [PW-1:0]        ptr);
    logic [PW:0] res;
    int          idx;
    res = '0;
    for (int k = N_PLAYERS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_PLAYERS;
      if (req[idx]) res = {1'b1, PW'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < N_PLAYERS; i++) begin
      level_d[i] = level_q[i];
      cnt_d[i]   = '0;
      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = s2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign rise_s        = level_d & ~level_q;
  assign pick_s        = rr_pick(pending_q, rr_q);
  assign grant_valid_s = pick_s[PW];
  assign grant_idx_s   = pick_s[PW-1:0];

  // A rise on the channel granted this edge is queued again rather than dropped.
  always_comb begin
    pending_d = pending_q;
    click_d   = '0;
    overrun_d = '0;
    rr_d      = rr_q;
    if (enable) begin
      if (grant_valid_s) begin
        click_d[grant_idx_s]   = 1'b1;
        pending_d[grant_idx_s] = 1'b0;
        rr_d                   = PW'((int'(grant_idx_s) + 1) % N_PLAYERS);
      end else begin
        click_d = '0;
      end
      for (int i = 0; i < N_PLAYERS; i++) begin
        if (rise_s[i] && pending_q[i] && !(grant_valid_s && grant_idx_s == PW'(i))) begin
          overrun_d[i] = 1'b1;
        end else if (rise_s[i]) begin
          pending_d[i] = 1'b1;
        end else begin
          overrun_d[i] = 1'b0;
        end
      end
    end else begin
      pending_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      pending_q <= '0;
      click_q   <= '0;
      overrun_q <= '0;
      rr_q      <= '0;
      for (int i = 0; i < N_PLAYERS; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= btn_raw;
      s2_q      <= s1_q;
      level_q   <= level_d;
      pending_q <= pending_d;
      click_q   <= click_d;
      overrun_q <= overrun_d;
      rr_q      <= rr_d;
      for (int i = 0; i < N_PLAYERS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign click     = click_q;
  assign btn_level = level_q;
  assign overrun   = overrun_q;

endmodule
